// File: rtl/write_back_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds FIFO/starvation defaults, state encoding and the register one-hot helper.
package write_back_arbiter_pkg;

    localparam int unsigned WB_FIFO_DEPTH   = 2;
    localparam int unsigned WB_STARVE_LIMIT = 4;
    localparam int unsigned WB_REG_W        = 5;
    localparam int unsigned WB_DATA_W       = 32;
    localparam int unsigned WB_NUM_REGS     = 32;

    typedef logic [WB_REG_W-1:0]    wb_reg_t;
    typedef logic [WB_DATA_W-1:0]   wb_data_t;
    typedef logic [WB_NUM_REGS-1:0] wb_mask_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

    // x0 is hard-wired zero, so it never contributes a pending bit.
    function automatic wb_mask_t wb_reg_onehot(input wb_reg_t r);
        wb_mask_t oh;
        oh = '0;
        if (r != '0) begin
            oh[r] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/write_back_arbiter_fifo.sv
// LU result queue: storage, wrap-bit pointers, live bits, kill-by-register
// and the pending-register mask derived from the registered entries.
module wb_result_fifo
    import write_back_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WB_REG_W-1:0]   push_reg_i,
    input  logic [WB_DATA_W-1:0]  push_val_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [WB_REG_W-1:0]   kill_reg_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  last_o,
    output logic                  head_live_o,
    output logic [WB_REG_W-1:0]   head_reg_o,
    output logic [WB_DATA_W-1:0]  head_val_o,
    output logic [WB_NUM_REGS-1:0] mask_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;
    logic [AW:0]          occ;
    logic [DEPTH-1:0]     live_q;
    wb_reg_t              dst_q [DEPTH];
    wb_data_t             val_q [DEPTH];

    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        rd_idx;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign occ     = wr_ptr_q - rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign last_o  = (occ == (AW+1)'(1));

    assign head_live_o = live_q[rd_idx];
    assign head_reg_o  = dst_q[rd_idx];
    assign head_val_o  = val_q[rd_idx];

    // Later non-blocking writes win: an entry pushed this cycle survives a
    // same-cycle kill. Push and pop never share a slot (full blocks push).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
        end else begin
            if (kill_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (live_q[i] && (dst_q[i] == kill_reg_i)) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
            if (pop_i) begin
                live_q[rd_idx] <= 1'b0;
                rd_ptr_q       <= rd_ptr_q + (AW+1)'(1);
            end
            if (push_i) begin
                live_q[wr_idx] <= 1'b1;
                wr_ptr_q       <= wr_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            dst_q[wr_idx] <= push_reg_i;
            val_q[wr_idx] <= push_val_i;
        end
    end

    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                mask_o = mask_o | wb_reg_onehot(dst_q[i]);
            end
        end
    end

endmodule

// File: rtl/write_back_arbiter.sv
// Shares the register-file write port between in-order write-back and a
// long-latency unit whose results queue up; a starvation guard forces drains.
module write_back_arbiter
    import write_back_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_wb_valid,
    input  logic [WB_REG_W-1:0]    pipe_wb_register,
    input  logic [WB_DATA_W-1:0]   pipe_wb_value,
    input  logic                   lu_valid,
    input  logic [WB_REG_W-1:0]    lu_register,
    input  logic [WB_DATA_W-1:0]   lu_value,
    output logic                   lu_ready,
    output logic                   rf_write_enable,
    output logic [WB_REG_W-1:0]    rf_write_register,
    output logic [WB_DATA_W-1:0]   rf_write_value,
    output logic                   pipe_stall,
    output logic [WB_NUM_REGS-1:0] pending_register_mask
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    wb_state_e      state_q;
    logic [CW-1:0]  count_q;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_last;
    logic           head_live;
    wb_reg_t        head_reg;
    wb_data_t       head_val;

    logic           pipe_write;
    logic           push;
    logic           pop;
    logic           blocked;
    logic           empty_d;

    assign pipe_stall = (state_q == DRAIN);
    assign lu_ready   = !fifo_full && !rst;
    assign pipe_write = pipe_wb_valid && !pipe_stall;
    // Results for x0 are acknowledged but never stored.
    assign push       = lu_valid && lu_ready && (lu_register != '0);
    assign pop        = !pipe_write && !fifo_empty;
    assign blocked    = pipe_write && !fifo_empty;
    assign empty_d    = fifo_empty ? !push : (fifo_last && pop && !push);

    wb_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_reg_i  (lu_register),
        .push_val_i  (lu_value),
        .pop_i       (pop),
        .kill_i      (pipe_write),
        .kill_reg_i  (pipe_wb_register),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .last_o      (fifo_last),
        .head_live_o (head_live),
        .head_reg_o  (head_reg),
        .head_val_o  (head_val),
        .mask_o      (pending_register_mask)
    );

    always_comb begin
        rf_write_enable   = 1'b0;
        rf_write_register = '0;
        rf_write_value    = '0;
        if (pipe_write) begin
            rf_write_enable   = 1'b1;
            rf_write_register = pipe_wb_register;
            rf_write_value    = pipe_wb_value;
        end else if (!fifo_empty) begin
            rf_write_enable   = head_live;
            rf_write_register = head_reg;
            rf_write_value    = head_val;
        end
        if (rst) begin
            rf_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (push) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (empty_d) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (pop) begin
                        count_q <= '0;
                    end else if (blocked) begin
                        // Starved long enough, or the LU is stuck behind a full queue.
                        if ((count_q == CW'(STARVE_LIMIT - 1)) || (fifo_full && lu_valid)) begin
                            state_q <= DRAIN;
                            count_q <= '0;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    count_q <= '0;
                    if (empty_d) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed bench for write_back_arbiter: hand-computed expectations per cycle.
module tb_write_back_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_register;
    logic [31:0] pipe_wb_value;
    logic        lu_valid;
    logic [4:0]  lu_register;
    logic [31:0] lu_value;
    logic        lu_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_value;
    logic        pipe_stall;
    logic [31:0] pending_register_mask;

    int unsigned n_checks;
    int unsigned n_pass;

    write_back_arbiter #(
        .DEPTH       (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pipe_wb_valid        (pipe_wb_valid),
        .pipe_wb_register     (pipe_wb_register),
        .pipe_wb_value        (pipe_wb_value),
        .lu_valid             (lu_valid),
        .lu_register          (lu_register),
        .lu_value             (lu_value),
        .lu_ready             (lu_ready),
        .rf_write_enable      (rf_write_enable),
        .rf_write_register    (rf_write_register),
        .rf_write_value       (rf_write_value),
        .pipe_stall           (pipe_stall),
        .pending_register_mask(pending_register_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                          input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        pipe_wb_valid    = wv;
        pipe_wb_register = wr;
        pipe_wb_value    = wd;
        lu_valid         = lv;
        lu_register      = lr;
        lu_value         = ld;
        #1;
    endtask

    // Fill both entries while the pipeline writes x1, holding lu_valid into a third offer.
    task automatic fill_two(input logic [4:0] ra, input logic [31:0] va,
                            input logic [4:0] rb, input logic [31:0] vb);
        set_in(1'b1, 5'd1, 32'h1000, 1'b1, ra, va);
        check("fill_ready0", {31'd0, lu_ready}, 32'd1);
        next_cycle();
        set_in(1'b1, 5'd1, 32'h1001, 1'b1, rb, vb);
        check("fill_ready1", {31'd0, lu_ready}, 32'd1);
        next_cycle();
        set_in(1'b1, 5'd1, 32'h1002, 1'b1, 5'd12, 32'hC0);
        check("fill_full_ready", {31'd0, lu_ready}, 32'd0);
        check("fill_full_rfreg", {27'd0, rf_write_register}, 32'd1);
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        set_in(1'b1, 5'd3, 32'hFFFF, 1'b1, 5'd5, 32'h77);
        next_cycle();
        next_cycle();

        // Reset state
        check("rst_stall", {31'd0, pipe_stall}, 32'd0);
        check("rst_mask", pending_register_mask, 32'd0);
        check("rst_ready", {31'd0, lu_ready}, 32'd0);
        check("rst_we", {31'd0, rf_write_enable}, 32'd0);

        // Idle pipeline, LU x5 = 0x1234
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        check("t1_ready", {31'd0, lu_ready}, 32'd1);
        check("t1_we0", {31'd0, rf_write_enable}, 32'd0);
        check("t1_mask0", pending_register_mask, 32'd0);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t1_we1", {31'd0, rf_write_enable}, 32'd1);
        check("t1_reg", {27'd0, rf_write_register}, 32'd5);
        check("t1_val", rf_write_value, 32'h1234);
        check("t1_mask1", pending_register_mask, 32'h0000_0020);
        next_cycle();
        check("t1_mask2", pending_register_mask, 32'd0);
        check("t1_we2", {31'd0, rf_write_enable}, 32'd0);

        // Starvation: continuous pipeline writes, one LU entry x6
        next_cycle();
        set_in(1'b1, 5'd1, 32'h100, 1'b1, 5'd6, 32'h66);
        check("t2_pipe_we", {31'd0, rf_write_enable}, 32'd1);
        check("t2_pipe_val", rf_write_value, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            set_in(1'b1, 5'd1, 32'h100 + 32'(k), 1'b0, 5'd0, 32'h0);
            check("t2_nostall", {31'd0, pipe_stall}, 32'd0);
            check("t2_blkval", rf_write_value, 32'h100 + 32'(k));
        end
        next_cycle();
        set_in(1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'h0);
        check("t2_stall", {31'd0, pipe_stall}, 32'd1);
        check("t2_lu_we", {31'd0, rf_write_enable}, 32'd1);
        check("t2_lu_reg", {27'd0, rf_write_register}, 32'd6);
        check("t2_lu_val", rf_write_value, 32'h66);
        next_cycle();
        set_in(1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'h0);
        check("t2_unstall", {31'd0, pipe_stall}, 32'd0);
        check("t2_resume", rf_write_value, 32'h105);
        next_cycle();

        // Kill: LU x7 queued, then pipeline writes x7
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hAAAA);
        next_cycle();
        set_in(1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 32'h0);
        check("t3_mask7", pending_register_mask, 32'h0000_0080);
        check("t3_reg", {27'd0, rf_write_register}, 32'd7);
        check("t3_val", rf_write_value, 32'h5555);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t3_dead_we", {31'd0, rf_write_enable}, 32'd0);
        check("t3_mask_clr", pending_register_mask, 32'd0);
        next_cycle();
        check("t3_after_we", {31'd0, rf_write_enable}, 32'd0);

        // Same-cycle push and pipeline write to x9: entry stays live
        set_in(1'b1, 5'd9, 32'h9999, 1'b1, 5'd9, 32'h99);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t3b_mask", pending_register_mask, 32'h0000_0200);
        check("t3b_we", {31'd0, rf_write_enable}, 32'd1);
        check("t3b_val", rf_write_value, 32'h99);
        next_cycle();

        // Fill DEPTH=2 while busy: forced drain of 2 cycles in FIFO order
        fill_two(5'd10, 32'hA0, 5'd11, 32'hB0);
        set_in(1'b1, 5'd1, 32'h1003, 1'b0, 5'd0, 32'h0);
        check("t4_stall0", {31'd0, pipe_stall}, 32'd1);
        check("t4_mask0", pending_register_mask, 32'h0000_0C00);
        check("t4_reg0", {27'd0, rf_write_register}, 32'd10);
        check("t4_val0", rf_write_value, 32'hA0);
        next_cycle();
        check("t4_stall1", {31'd0, pipe_stall}, 32'd1);
        check("t4_mask1", pending_register_mask, 32'h0000_0800);
        check("t4_reg1", {27'd0, rf_write_register}, 32'd11);
        check("t4_val1", rf_write_value, 32'hB0);
        next_cycle();
        check("t4_stall2", {31'd0, pipe_stall}, 32'd0);
        check("t4_pipe_reg", {27'd0, rf_write_register}, 32'd1);
        check("t4_mask2", pending_register_mask, 32'd0);

        // LU result to x0: accepted, discarded
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        check("t5_ready", {31'd0, lu_ready}, 32'd1);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t5_we", {31'd0, rf_write_enable}, 32'd0);
        check("t5_mask", pending_register_mask, 32'd0);
        next_cycle();
        check("t5_stall", {31'd0, pipe_stall}, 32'd0);

        // Reset during drain with 2 entries
        fill_two(5'd13, 32'hD0, 5'd14, 32'hE0);
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t6_stall_pre", {31'd0, pipe_stall}, 32'd1);
        check("t6_we_rst", {31'd0, rf_write_enable}, 32'd0);
        check("t6_ready_rst", {31'd0, lu_ready}, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("t6_stall", {31'd0, pipe_stall}, 32'd0);
        check("t6_mask", pending_register_mask, 32'd0);
        check("t6_we", {31'd0, rf_write_enable}, 32'd0);
        next_cycle();
        check("t6_we2", {31'd0, rf_write_enable}, 32'd0);
        check("t6_ready", {31'd0, lu_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
